exc_ctrl: RTL

Exception request controller for the single-cycle exception datapath. Collects up to `NSRC` exception sources and applies a per-source enable mask. Selects one source by fixed priority and raises `Exc` with the matching `EStatus` code to the exception unit. It then tracks the handler lifetime (`ExcAck` to `ERet`) so that no new exception is raised until the current handler returns.

---
 rtl/exc_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : Exception request controller. It latches and masks requests,
//               dispatches them by fixed priority, and blocks nesting until ERet.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
  parameter int NSRC        = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_req,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            ExcAck,
  input  logic            ERet,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic            busy,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic            ack_timeout
);

  localparam int c_cnt_w = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_tmo_max = c_cnt_w'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAISE   = 2'd1,
    ST_HANDLER = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_exc;
  logic                w_exc_nxt;
  logic [3:0]          r_estatus;
  logic [3:0]          w_estatus_nxt;
  logic [NSRC-1:0]     r_pending;
  logic [NSRC-1:0]     w_pending_nxt;
  logic [NSRC-1:0]     r_mask;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [c_cnt_w-1:0]  w_cnt_inc;
  logic                r_timeout;
  logic                w_timeout_nxt;

  logic [NSRC-1:0]     w_elig;
  logic [NSRC-1:0]     w_win_oh;
  logic [3:0]          w_win_idx;
  logic                w_any;

  assign w_elig    = (r_pending | src_req) & r_mask;
  assign w_any     = |w_elig;
  assign w_cnt_inc = (r_cnt == c_tmo_max) ? r_cnt : r_cnt + 1'b1;

  // Scanning downwards lets the lowest set index overwrite the others.
  always_comb begin
    w_win_idx = '0;
    w_win_oh  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_idx   = 4'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_exc_nxt     = r_exc;
    w_estatus_nxt = r_estatus;
    w_pending_nxt = r_pending | src_req;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_IDLE: begin
        w_exc_nxt = 1'b0;
        w_cnt_nxt = '0;
        if (w_any) begin
          w_state_nxt   = ST_RAISE;
          w_exc_nxt     = 1'b1;
          w_estatus_nxt = w_win_idx + 4'd1;
          // The request sampled on the dispatch edge is consumed by it.
          w_pending_nxt = (r_pending | src_req) & ~w_win_oh;
        end
      end
      ST_RAISE: begin
        w_exc_nxt = 1'b1;
        if (ExcAck) begin
          w_state_nxt = ST_HANDLER;
          w_exc_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == c_tmo_max) begin
            w_timeout_nxt = 1'b1;
          end
        end
      end
      ST_HANDLER: begin
        w_exc_nxt = 1'b0;
        if (ERet) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_exc_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_exc     <= 1'b0;
      r_estatus <= 4'd0;
      r_pending <= '0;
      r_mask    <= '1;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_exc     <= w_exc_nxt;
      r_estatus <= w_estatus_nxt;
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
    end
  end

  assign Exc         = r_exc;
  assign EStatus     = r_estatus;
  assign busy        = (r_state != ST_IDLE);
  assign pending     = r_pending;
  assign mask        = r_mask;
  assign ack_timeout = r_timeout;

endmodule
`default_nettype wire
